// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: a DEPTH x 32-bit word store answering
// valid/ready requests with a fixed LATENCY and per-response error flag.
module data_mem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  txn_count,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic        accept, addr_err, resp_fire;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the initiator holds req_* stable until req_ready, and the
  // responder holds resp_* stable until resp_ready.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;
  assign resp_fire  = resp_valid & resp_ready;
  assign idx        = req_addr[AW-1:0];
  assign addr_err   = |(req_addr >> AW);
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if (resp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset wins over any acceptance on the same edge, so an in-flight or
  // just-presented write never lands in memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      txn_count  <= 8'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (resp_fire) txn_count <= txn_count + 8'd1;
      if (accept) begin
        resp_err   <= addr_err;
        resp_rdata <= (!req_we && !addr_err) ? mem[idx] : 32'd0;
        if (req_we && !addr_err) mem[idx] <= req_wdata;
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of 32-bit words stored (power of two, 2..256).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to response valid (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, 32 bits: word address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: write data.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: response presented.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: initiator accepts the response.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: read data; 0 for writes and errors.
REQ-013 The block SHALL have port resp_err, output, 1 bit: address out of range.
REQ-014 The block SHALL have port txn_count, output, 8 bits: completed responses, wrapping.

Function
REQ-015 The block SHALL implement states IDLE, WAIT, RESP; at most one transaction outstanding.
REQ-016 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-017 On acceptance: latch req_we and error flag; error = any of req_addr[31:log2(DEPTH)] nonzero.
REQ-018 On accepted in-range write: memory word req_addr[log2(DEPTH)-1:0] SHALL take req_wdata at that same edge.
REQ-019 On accepted in-range read: the word SHALL be sampled at that edge into a response register; out-of-range accesses SHALL not modify memory.
REQ-020 Transitions: IDLE->RESP on acceptance if LATENCY=1; IDLE->WAIT otherwise, loading down-counter with LATENCY-1.
REQ-021 WAIT: decrement each cycle; WAIT->RESP on the edge where the counter equals 1.
REQ-022 resp_valid SHALL be 1 exactly in RESP, first asserted LATENCY cycles after the acceptance edge.
REQ-023 resp_rdata and resp_err SHALL stay stable while resp_valid=1 and resp_ready=0 (backpressure, unbounded hold).
REQ-024 RESP->IDLE on resp_valid & resp_ready; txn_count SHALL increment by 1 (mod 256) on that edge.
REQ-025 A new request SHALL not be accepted on the response-handshake edge; earliest acceptance is the following cycle (req_ready=1 in IDLE).
REQ-026 req_valid asserted in WAIT/RESP SHALL be ignored and not stored; the initiator holds it until req_ready.
REQ-027 Write responses SHALL have resp_rdata=0; error responses SHALL have resp_rdata=0, resp_err=1.

Reset
REQ-028 rst=1 at a rising edge SHALL force state IDLE, counter 0, txn_count 0, resp_valid 0, resp_rdata 0, resp_err 0, and clear all DEPTH words to 0.
REQ-029 rst SHALL take priority over any in-flight transaction; a write accepted on the reset edge SHALL not be committed, and no response for an aborted transaction SHALL appear afterwards.
REQ-030 After rst deasserts, req_ready SHALL be 1 on the first following cycle.

Verification
REQ-031 Reset then read addr 5 (LATENCY=2) -> resp_valid 2 cycles after acceptance, rdata 0x00000000, err 0, txn_count 1.
REQ-032 Write 0xDEADBEEF to addr 3, then read addr 3 -> write resp rdata 0; read resp rdata 0xDEADBEEF; txn_count 2.
REQ-033 Read addr 0x00000020 (DEPTH=32) -> resp_err 1, rdata 0; prior write to addr 0 of 0x1234 still reads 0x1234.
REQ-034 Hold resp_ready=0 for 5 cycles during RESP -> resp_valid, rdata, err stable; req_ready 0 throughout; txn_count unchanged until handshake.
REQ-035 Assert rst during WAIT of a write to addr 7 -> IDLE next cycle, no response, addr 7 reads 0, txn_count 0.
REQ-036 256 back-to-back transactions with resp_ready=1 -> txn_count wraps to 0; each accepted in the cycle after the previous handshake.
